comp_filter_mc: RTL and testbench
=================================

# comp_filter_mc

Multi-channel, time-multiplexed complementary attitude filter and the parametrised successor of the fixed three-axis blend stage. Unlike the stateless blend, it keeps a per-channel angle state and integrates gyro rate into it each update: angle = α·(angle + gyro·dt) + (1−α)·acc. A per-channel mask makes channels with no accelerometer reference (yaw) pure gyro integrators instead of being forced to zero. One shared multiplier is sequenced by an FSM. The block sits between the IMU sample formatter and the attitude PID stage.

## Interface
Parameters:
- DATA_W, 16, signed width of gyro, acc and angle samples
- CH, 3, channel count (0 = pitch, 1 = roll, 2 = yaw by convention)
- ALPHA_W, 8, α fraction bits; α = 2^ALPHA_W represents 1.0
- DT_SHIFT, 8, gyro·dt implemented as arithmetic right shift by DT_SHIFT

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins one update of all channels
- clear  in  1  synchronous; zeroes angle state, honoured only in IDLE
- alpha  in  ALPHA_W+1  unsigned α; values above 2^ALPHA_W clamp to 2^ALPHA_W
- acc_mask  in  CH  bit c = 1: blend acc into channel c; 0: gyro-only
- gyro_in  in  CH·DATA_W  packed signed rates, channel c at [c·DATA_W +: DATA_W]
- acc_in  in  CH·DATA_W  packed signed accelerometer angles, same packing
- angle_out  out  CH·DATA_W  packed signed filtered angles (registered state)
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  single-cycle pulse when all channels are updated
- sat  out  1  high for the done cycle if any channel clipped during that update

## Operation
- FSM states: IDLE, MUL_A, MUL_B, DONE.
- IDLE: start=1 captures alpha (clamped), acc_mask, gyro_in and acc_in into shadow registers, sets ch=0 → MUL_A. Inputs may change freely while busy.
- MUL_A: pred = angle[ch] + (gyro[ch] >>> DT_SHIFT), DATA_W+1 bits, unclipped. When acc_mask[ch]=1, a_eff = α; otherwise a_eff = 2^ALPHA_W. acc_reg = a_eff·pred. → MUL_B.
- MUL_B: sum = acc_reg + (2^ALPHA_W − a_eff)·acc[ch]. result = (sum + 2^(ALPHA_W−1)) >>> ALPHA_W, i.e. round half up. Clip to DATA_W (see Configuration) and write angle[ch]. If ch = CH−1 → DONE; otherwise ch+1 → MUL_A.
- DONE: done=1, sat=1 if any clip occurred during this update. → IDLE.
- Internal products are wide enough never to overflow: DATA_W+ALPHA_W+3 bits signed.
- start while not IDLE is ignored; no queuing.
- clear and start asserted together in IDLE: clear wins and start is dropped. clear outside IDLE is ignored.
- Channels are updated in ascending order. angle_out[c] changes only on its MUL_B cycle.

## Timing
- Reset values: angle_out = 0 for all channels, busy=0, done=0, sat=0, FSM=IDLE, ch=0.
- Accepted start at cycle T: busy=1 over T+1 … T+2·CH+1; done=1 at T+2·CH+1 (T+7 with defaults); IDLE at T+2·CH+2. A new start is accepted in that IDLE cycle.
- Channel c is written at the edge ending cycle T+2c+2.
- Reset mid-update aborts immediately. All state returns to reset values and no done is produced.

## Configuration
- FILTER_SAT_EN defined: result outside [−2^(DATA_W−1), 2^(DATA_W−1)−1] clamps to the nearest bound and sets the internal clip flag.
- FILTER_SAT_EN undefined: result truncates to its low DATA_W bits (two's-complement wrap), which keeps the angle continuous for ±180° encodings. sat is tied to 0.

## Test plan
All scenarios use default parameters.
- Reset, then α=256, acc_mask=3'b111, gyro=256 on all channels, acc=0, one start → angle_out = 1,1,1; done at T+7; busy high for exactly 7 cycles.
- α=0, acc_mask=3'b011, acc=1000 on all channels, gyro=512 on all channels → ch0 = ch1 = 1000, ch2 = 2; a second start gives ch2 = 4.
- Rounding: state 0, α=128, acc=3, gyro=0, mask all 1 → all channels 2 (384+128 = 512, >>8 = 2). α=300 gives the same result as α=256.
- Overflow: preload angle=32767 by running α=0 with acc=32767, then α=256 and gyro=1024 → with FILTER_SAT_EN, angle=32767 and sat=1 on done; without it, angle=−32765 and sat=0.
- Start pulsed again at T+3 during busy → ignored; exactly one done, at T+7. clear at T+3 → ignored. clear in IDLE → all angles 0.
- Assert rst_n=0 at T+4 → angle_out, busy, done and sat are 0 asynchronously; no done pulse follows after release.

Source files
------------

// File: rtl/comp_filter_mc.sv
// comp_filter_mc
// Time-multiplexed complementary attitude filter for CH channels. Each update
// computes, per channel and in ascending order:
//   angle = a_eff*(angle + (gyro >>> DT_SHIFT)) + (2^ALPHA_W - a_eff)*acc
// rounded half up and scaled back by 2^ALPHA_W. a_eff is alpha for channels
// whose acc_mask bit is set, and 1.0 otherwise, so those channels become pure
// gyro integrators. A single multiplier is shared between the two products of
// each channel, which takes two cycles per channel.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   start            one-cycle pulse, begins an update (IDLE only)
//   clear            zeroes all angle state (IDLE only, wins over start)
//   alpha            unsigned blend weight, clamped to 2^ALPHA_W
//   acc_mask         per-channel enable of the accelerometer blend
//   gyro_in, acc_in  packed signed samples, channel c at [c*DATA_W +: DATA_W]
//   angle_out        packed signed filtered angles (registered state)
//   busy             high while an update is in progress, including DONE
//   done             one-cycle pulse when all channels are written
//   sat              high with done if any channel clipped in that update
//
// Build option: define FILTER_SAT_EN to clamp out-of-range results to the
// DATA_W signed range and report it on sat. Without it results wrap
// (two's complement), which keeps +/-180 degree encodings continuous, and sat
// is tied low.
//
// States:
//   IDLE  | waiting for start; clear honoured here
//   MUL_A | acc_reg = a_eff * (angle + gyro*dt) for channel ch
//   MUL_B | add (1 - a_eff) * acc, round, clip/wrap, write angle[ch]
//   DONE  | done pulse, sat reported; back to IDLE

module comp_filter_mc #(
  parameter int DATA_W   = 16,
  parameter int CH       = 3,
  parameter int ALPHA_W  = 8,
  parameter int DT_SHIFT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [ALPHA_W:0]       alpha,
  input  logic [CH-1:0]          acc_mask,
  input  logic [CH*DATA_W-1:0]   gyro_in,
  input  logic [CH*DATA_W-1:0]   acc_in,
  output logic [CH*DATA_W-1:0]   angle_out,
  output logic                   busy,
  output logic                   done,
  output logic                   sat
);

  localparam int PW = DATA_W + ALPHA_W + 3;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [ALPHA_W:0]        ALPHA_ONE = {1'b1, {ALPHA_W{1'b0}}};
  localparam logic signed [PW-1:0]    RND       = PW'(1) << (ALPHA_W - 1);
  localparam logic [CW-1:0]           CH_LAST   = CW'(CH - 1);

  typedef enum logic [1:0] {IDLE, MUL_A, MUL_B, DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0]                ch_q, ch_d;
  logic [ALPHA_W:0]             alpha_sh_q, alpha_sh_d;
  logic [CH-1:0]                mask_sh_q, mask_sh_d;
  logic signed [DATA_W-1:0]     gyro_sh_q [CH];
  logic signed [DATA_W-1:0]     gyro_sh_d [CH];
  logic signed [DATA_W-1:0]     acc_sh_q [CH];
  logic signed [DATA_W-1:0]     acc_sh_d [CH];
  logic signed [DATA_W-1:0]     angle_q [CH];
  logic signed [DATA_W-1:0]     angle_d [CH];
  logic signed [PW-1:0]         acc_reg_q, acc_reg_d;
`ifdef FILTER_SAT_EN
  logic                         sat_flag_q, sat_flag_d;
`endif

  // Shared datapath
  logic [ALPHA_W:0]             a_eff;
  logic signed [DATA_W-1:0]     angle_cur, gyro_cur, acc_cur, gyro_dt;
  logic signed [DATA_W:0]       pred;
  logic signed [ALPHA_W+1:0]    mul_x;
  logic signed [DATA_W:0]       mul_y;
  logic signed [PW-1:0]         mul_p, sum, rnd_sum, res_wide;
  logic signed [DATA_W-1:0]     res;
  logic                         clip;

  always_comb begin
    angle_cur = angle_q[ch_q];
    gyro_cur  = gyro_sh_q[ch_q];
    acc_cur   = acc_sh_q[ch_q];
    a_eff     = mask_sh_q[ch_q] ? alpha_sh_q : ALPHA_ONE;
    gyro_dt   = gyro_cur >>> DT_SHIFT;
    pred      = {angle_cur[DATA_W-1], angle_cur} + {gyro_dt[DATA_W-1], gyro_dt};
    if (state_q == MUL_B) begin
      mul_x = {1'b0, ALPHA_ONE - a_eff};
      mul_y = {acc_cur[DATA_W-1], acc_cur};
    end else begin
      mul_x = {1'b0, a_eff};
      mul_y = pred;
    end
    // Both operands sign-extended to PW; the true product always fits, so the
    // truncated unsigned product is the exact signed result.
    mul_p    = {{(PW-ALPHA_W-2){mul_x[ALPHA_W+1]}}, mul_x} *
               {{(PW-DATA_W-1){mul_y[DATA_W]}}, mul_y};
    sum      = acc_reg_q + mul_p;
    rnd_sum  = sum + RND;
    res_wide = rnd_sum >>> ALPHA_W;
  end

`ifdef FILTER_SAT_EN
  localparam logic signed [PW-1:0] MAX_V = PW'((2**(DATA_W-1)) - 1);
  localparam logic signed [PW-1:0] MIN_V = PW'(-(2**(DATA_W-1)));

  always_comb begin
    clip = 1'b0;
    res  = res_wide[DATA_W-1:0];
    if (res_wide > MAX_V) begin
      clip = 1'b1;
      res  = MAX_V[DATA_W-1:0];
    end else if (res_wide < MIN_V) begin
      clip = 1'b1;
      res  = MIN_V[DATA_W-1:0];
    end
  end
`else
  logic unused_res_hi;
  assign res  = res_wide[DATA_W-1:0];
  assign clip = 1'b0;
  assign unused_res_hi = ^{res_wide[PW-1:DATA_W], clip};
`endif

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      alpha_sh_q <= '0;
      mask_sh_q  <= '0;
      acc_reg_q  <= '0;
      for (int i = 0; i < CH; i++) begin
        gyro_sh_q[i] <= '0;
        acc_sh_q[i]  <= '0;
        angle_q[i]   <= '0;
      end
`ifdef FILTER_SAT_EN
      sat_flag_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      alpha_sh_q <= alpha_sh_d;
      mask_sh_q  <= mask_sh_d;
      acc_reg_q  <= acc_reg_d;
      gyro_sh_q  <= gyro_sh_d;
      acc_sh_q   <= acc_sh_d;
      angle_q    <= angle_d;
`ifdef FILTER_SAT_EN
      sat_flag_q <= sat_flag_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !clear) state_d = MUL_A;
      MUL_A:   state_d = MUL_B;
      MUL_B:   state_d = (ch_q == CH_LAST) ? DONE : MUL_A;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    ch_d       = ch_q;
    alpha_sh_d = alpha_sh_q;
    mask_sh_d  = mask_sh_q;
    acc_reg_d  = acc_reg_q;
    gyro_sh_d  = gyro_sh_q;
    acc_sh_d   = acc_sh_q;
    angle_d    = angle_q;
`ifdef FILTER_SAT_EN
    sat_flag_d = sat_flag_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear) begin
          for (int i = 0; i < CH; i++) angle_d[i] = '0;
        end else if (start) begin
          alpha_sh_d = (alpha > ALPHA_ONE) ? ALPHA_ONE : alpha;
          mask_sh_d  = acc_mask;
          for (int i = 0; i < CH; i++) begin
            gyro_sh_d[i] = gyro_in[i*DATA_W +: DATA_W];
            acc_sh_d[i]  = acc_in[i*DATA_W +: DATA_W];
          end
          ch_d = '0;
`ifdef FILTER_SAT_EN
          sat_flag_d = 1'b0;
`endif
        end
      end
      MUL_A: acc_reg_d = mul_p;
      MUL_B: begin
        angle_d[ch_q] = res;
        ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);
`ifdef FILTER_SAT_EN
        sat_flag_d = sat_flag_q | clip;
`endif
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
`ifdef FILTER_SAT_EN
    sat  = (state_q == DONE) && sat_flag_q;
`else
    sat  = 1'b0;
`endif
    for (int i = 0; i < CH; i++) angle_out[i*DATA_W +: DATA_W] = angle_q[i];
  end

endmodule

// File: tb/tb_comp_filter_mc.sv
module tb_comp_filter_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [8:0]  alpha = '0;
  logic [2:0]  acc_mask = '0;
  logic [47:0] gyro_in = '0;
  logic [47:0] acc_in = '0;
  logic [47:0] angle_out;
  logic        busy, done, sat;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_angle [3];
  int m_sat;
  int gy [3];
  int ac [3];

  // Observations from the last run_update
  int o_done_at, o_busy_cnt, o_ndone, o_sat_done, o_sat_other;

  comp_filter_mc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .alpha(alpha),
    .acc_mask(acc_mask), .gyro_in(gyro_in), .acc_in(acc_in),
    .angle_out(angle_out), .busy(busy), .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  function automatic int got_angle(input int c);
    logic signed [15:0] v;
    v = angle_out[c*16 +: 16];
    return int'(v);
  endfunction

  function automatic int s16(input int x);
    logic signed [15:0] v;
    v = x[15:0];
    return int'(v);
  endfunction

  // angle = a*(angle + gyro/256) + (1-a)*acc, a in 1/256 units, round half up
  function automatic void model_update(input int a_in, input int mask);
    int ae, pred, s, r;
    m_sat = 0;
    for (int c = 0; c < 3; c++) begin
      ae = mask[c] ? ((a_in > 256) ? 256 : a_in) : 256;
      pred = m_angle[c] + (gy[c] >>> 8);
      s = ae * pred + (256 - ae) * ac[c];
      r = (s + 128) >>> 8;
`ifdef FILTER_SAT_EN
      if (r > 32767) begin r = 32767; m_sat = 1; end
      if (r < -32768) begin r = -32768; m_sat = 1; end
`else
      r = ((r + 32768) & 65535) - 32768;
`endif
      m_angle[c] = r;
    end
  endfunction

  // Drive one update (start in cycle T), observe 12 cycles after it.
  task automatic run_update(input int a_in, input int mask, input int xs_k, input int xc_k);
    @(negedge clk);
    alpha = 9'(a_in);
    acc_mask = 3'(mask);
    for (int c = 0; c < 3; c++) begin
      gyro_in[c*16 +: 16] = 16'(gy[c]);
      acc_in[c*16 +: 16]  = 16'(ac[c]);
    end
    start = 1'b1;
    o_done_at = 0; o_busy_cnt = 0; o_ndone = 0; o_sat_done = 0; o_sat_other = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = (k == xs_k);
      clear = (k == xc_k);
      alpha = 9'($urandom);
      acc_mask = 3'($urandom);
      gyro_in = 48'({$urandom, $urandom});
      acc_in  = 48'({$urandom, $urandom});
      if (busy) o_busy_cnt++;
      if (done) begin
        o_ndone++;
        o_done_at = k;
        o_sat_done = int'(sat);
      end else if (sat) o_sat_other++;
    end
    start = 1'b0;
    clear = 1'b0;
    model_update(a_in, mask);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 3; c++) m_angle[c] = 0;
  endtask

  task automatic set_inputs(input int g, input int a);
    for (int c = 0; c < 3; c++) begin gy[c] = g; ac[c] = a; end
  endtask

  task automatic test_reset();
    n_vec++;
    if (angle_out !== 48'd0 || busy !== 1'b0 || done !== 1'b0 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: angle=%h busy=%b done=%b sat=%b, want all 0", angle_out, busy, done, sat);
    end
  endtask

  task automatic test_basic();
    set_inputs(256, 0);
    run_update(256, 3'b111, 0, 0);
    n_vec++;
    if (o_done_at !== 7 || o_ndone !== 1) begin
      n_err++;
      $display("FAIL basic_done_timing: done at T+%0d count %0d, want T+7 count 1", o_done_at, o_ndone);
    end
    n_vec++;
    if (o_busy_cnt !== 7) begin
      n_err++;
      $display("FAIL basic_busy_len: %0d cycles, want 7", o_busy_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (got_angle(c) !== 1 || m_angle[c] !== 1) begin
        n_err++;
        $display("FAIL basic_angle ch%0d: got %0d, want 1", c, got_angle(c));
      end
    end
  endtask

  task automatic test_gyro_only();
    int want2;
    do_clear();
    set_inputs(512, 1000);
    for (int r = 0; r < 2; r++) begin
      run_update(0, 3'b011, 0, 0);
      want2 = (r == 0) ? 2 : 4;
      for (int c = 0; c < 3; c++) begin
        n_vec++;
        if (got_angle(c) !== ((c == 2) ? want2 : 1000)) begin
          n_err++;
          $display("FAIL gyro_only run%0d ch%0d: got %0d, want %0d", r, c, got_angle(c), (c == 2) ? want2 : 1000);
        end
      end
    end
  endtask

  task automatic test_rounding();
    do_clear();
    set_inputs(0, 3);
    run_update(128, 3'b111, 0, 0);
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (got_angle(c) !== 2) begin
        n_err++;
        $display("FAIL rounding ch%0d: got %0d, want 2", c, got_angle(c));
      end
    end
    // alpha above 1.0 clamps: pure integration, acc ignored
    set_inputs(768, 30000);
    run_update(300, 3'b111, 0, 0);
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (got_angle(c) !== 5 || m_angle[c] !== 5) begin
        n_err++;
        $display("FAIL alpha_clamp ch%0d: got %0d, want 5", c, got_angle(c));
      end
    end
  endtask

  task automatic test_overflow();
    int want_a, want_s;
    do_clear();
    set_inputs(0, 32767);
    run_update(0, 3'b111, 0, 0);
    set_inputs(1024, 0);
    run_update(256, 3'b111, 0, 0);
`ifdef FILTER_SAT_EN
    want_a = 32767; want_s = 1;
`else
    want_a = -32765; want_s = 0;
`endif
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (got_angle(c) !== want_a) begin
        n_err++;
        $display("FAIL overflow ch%0d: got %0d, want %0d", c, got_angle(c), want_a);
      end
    end
    n_vec++;
    if (o_sat_done !== want_s || o_sat_other !== 0) begin
      n_err++;
      $display("FAIL overflow_sat: at done %0d, outside done %0d, want %0d and 0", o_sat_done, o_sat_other, want_s);
    end
  endtask

  task automatic test_busy_ignore();
    set_inputs(2560, 100);
    run_update(64, 3'b101, 3, 0);
    n_vec++;
    if (o_ndone !== 1 || o_done_at !== 7 || o_busy_cnt !== 7) begin
      n_err++;
      $display("FAIL start_while_busy: done count %0d at T+%0d busy %0d, want 1 at T+7 busy 7", o_ndone, o_done_at, o_busy_cnt);
    end
    run_update(200, 3'b110, 0, 3);
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (got_angle(c) !== m_angle[c]) begin
        n_err++;
        $display("FAIL clear_while_busy ch%0d: got %0d, want %0d", c, got_angle(c), m_angle[c]);
      end
    end
  endtask

  task automatic test_clear();
    do_clear();
    n_vec++;
    if (angle_out !== 48'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL clear_idle: angle=%h busy=%b, want 0 and 0", angle_out, busy);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    set_inputs(5000, 700);
    @(negedge clk);
    alpha = 9'd100; acc_mask = 3'b111;
    for (int c = 0; c < 3; c++) begin
      gyro_in[c*16 +: 16] = 16'(gy[c]);
      acc_in[c*16 +: 16]  = 16'(ac[c]);
    end
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (angle_out !== 48'd0 || busy !== 1'b0 || done !== 1'b0 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: angle=%h busy=%b done=%b sat=%b, want all 0", angle_out, busy, done, sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    n_vec++;
    if (nd !== 0) begin
      n_err++;
      $display("FAIL reset_mid_no_done: %0d busy/done cycles after release, want 0", nd);
    end
    for (int c = 0; c < 3; c++) m_angle[c] = 0;
  endtask

  task automatic test_random();
    logic signed [15:0] t;
    int a_in, mask, bad;
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < 3; c++) begin
        t = 16'($urandom); gy[c] = int'(t);
        t = 16'($urandom); ac[c] = int'(t);
      end
      a_in = $urandom_range(0, 511);
      mask = $urandom_range(0, 7);
      run_update(a_in, mask, (it % 3 == 0) ? $urandom_range(1, 6) : 0, 0);
      bad = 0;
      for (int c = 0; c < 3; c++) begin
        n_vec++;
        if (got_angle(c) !== m_angle[c]) begin
          n_err++;
          $display("FAIL random it%0d ch%0d: got %0d, want %0d", it, c, got_angle(c), m_angle[c]);
        end
      end
      n_vec++;
      if (o_done_at !== 7 || o_ndone !== 1 || o_sat_done !== m_sat || o_sat_other !== 0) begin
        n_err++;
        $display("FAIL random_ctrl it%0d: done T+%0d n%0d sat %0d/%0d, want T+7 n1 sat %0d/0",
                 it, o_done_at, o_ndone, o_sat_done, o_sat_other, m_sat);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++) m_angle[c] = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gyro_only();
    test_rounding();
    test_overflow();
    test_busy_ignore();
    test_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
